// File: rtl/fm_pan_mixer.sv
// fm_pan_mixer: time-multiplexed equal-power stereo panner with per-channel
// pan smoothing. Three stages: S0 state read/step/write, S1 gain lookup,
// S2 multiply/shift into the output registers.
module fm_pan_mixer #(
    parameter int CHANNELS  = 8,
    parameter int SAMPLE_W  = 16,
    parameter int PAN_W     = 7,
    parameter int RAMP_STEP = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pan_wr,
    input  logic [CH_W-1:0]            pan_ch,
    input  logic [PAN_W-1:0]           pan_val,
    input  logic                       in_valid,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch,
    output logic [SAMPLE_W-1:0]        out_l,
    output logic [SAMPLE_W-1:0]        out_r,
    output logic [CHANNELS-1:0]        ramp_active
);
    localparam int NPOS = 1 << PAN_W;
    localparam logic [PAN_W-1:0] CENTRE = PAN_W'(1 << (PAN_W - 1));

    // Quarter-cosine gain, 1 = full left gain, NPOS-1 = zero; 0 is mute.
    function automatic logic [7:0] gain_f(input int p);
        real a;
        int  r;
        if (p <= 0 || p >= NPOS) return 8'd0;
        a = real'(p - 1) * 3.14159265358979 / (2.0 * real'(NPOS - 2));
        r = $rtoi(255.0 * $cos(a) + 0.5);
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    // Move c toward t by at most RAMP_STEP without overshooting.
    function automatic logic [PAN_W-1:0] step_f(input logic [PAN_W-1:0] c,
                                                input logic [PAN_W-1:0] t);
        int ci;
        int ti;
        ci = int'(c);
        ti = int'(t);
        if (ti > ci)      ci = (ti - ci > RAMP_STEP) ? ci + RAMP_STEP : ti;
        else if (ci > ti) ci = (ci - ti > RAMP_STEP) ? ci - RAMP_STEP : ti;
        return PAN_W'(ci);
    endfunction

    logic [7:0] gtab [NPOS];
    for (genvar i = 0; i < NPOS; i++) begin : g_rom
        assign gtab[i] = gain_f(i);
    end

    logic [CHANNELS-1:0][PAN_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
    logic [CHANNELS-1:0]            ramp_d, ramp_q;
    logic [PAN_W-1:0]               s0_pos;
    logic                           s0_hit;
    logic [2:0]                     vld_pipe_q;

    logic [CH_W-1:0]            s1_ch_q, s2_ch_q, out_ch_q;
    logic signed [SAMPLE_W-1:0] s1_smp_q, s2_smp_q;
    logic [PAN_W-1:0]           s1_pos_q, s1_neg;
    logic [7:0]                 s2_gl_q, s2_gr_q;
    logic signed [SAMPLE_W+8:0] prod_l, prod_r;
    logic [SAMPLE_W-1:0]        out_l_q, out_r_q;

    // S0: apply the pan write first (forwarded), then step the sampled channel.
    always_comb begin
        tgt_d  = tgt_q;
        cur_d  = cur_q;
        ramp_d = '0;
        s0_pos = '0;
        s0_hit = in_valid && (int'(in_ch) < CHANNELS);
        for (int n = 0; n < CHANNELS; n++) begin
            if (pan_wr && int'(pan_ch) == n) begin
                tgt_d[n] = pan_val;
                if (RAMP_STEP == 0 || pan_val == '0 || cur_q[n] == '0)
                    cur_d[n] = pan_val;
            end
            if (in_valid && int'(in_ch) == n) begin
                cur_d[n] = step_f(cur_d[n], tgt_d[n]);
                s0_pos   = cur_d[n];
            end
            ramp_d[n] = (cur_d[n] != tgt_d[n]);
        end
    end

    // S1 right gain index is 2^PAN_W - p; wraps to 0 (mute) when p = 0.
    assign s1_neg = '0 - s1_pos_q;

    // S2: full-width signed product, arithmetic shift by 8 is a bit select.
    assign prod_l = (SAMPLE_W+9)'(s2_smp_q) * (SAMPLE_W+9)'($signed({1'b0, s2_gl_q}));
    assign prod_r = (SAMPLE_W+9)'(s2_smp_q) * (SAMPLE_W+9)'($signed({1'b0, s2_gr_q}));

    // Channel state, pipeline valids and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_q      <= {CHANNELS{CENTRE}};
            tgt_q      <= {CHANNELS{CENTRE}};
            ramp_q     <= '0;
            vld_pipe_q <= '0;
            s1_ch_q    <= '0;
            s1_smp_q   <= '0;
            s1_pos_q   <= '0;
            s2_ch_q    <= '0;
            s2_smp_q   <= '0;
            s2_gl_q    <= '0;
            s2_gr_q    <= '0;
            out_ch_q   <= '0;
            out_l_q    <= '0;
            out_r_q    <= '0;
        end else begin
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            ramp_q     <= ramp_d;
            vld_pipe_q <= {vld_pipe_q[1:0], s0_hit};
            s1_ch_q    <= in_ch;
            s1_smp_q   <= in_sample;
            s1_pos_q   <= s0_pos;
            s2_ch_q    <= s1_ch_q;
            s2_smp_q   <= s1_smp_q;
            s2_gl_q    <= gtab[s1_pos_q];
            s2_gr_q    <= gtab[s1_neg];
            if (vld_pipe_q[1]) begin
                out_ch_q <= s2_ch_q;
                out_l_q  <= prod_l[SAMPLE_W+7:8];
                out_r_q  <= prod_r[SAMPLE_W+7:8];
            end
        end
    end

    assign out_valid   = vld_pipe_q[2];
    assign out_ch      = out_ch_q;
    assign out_l       = out_l_q;
    assign out_r       = out_r_q;
    assign ramp_active = ramp_q;
endmodule

// File: tb/tb_fm_pan_mixer.sv
// Bench for fm_pan_mixer: directed test-plan steps plus random traffic,
// all checked against a channel-level model of the pan/ramp rules.
module tb_fm_pan_mixer;
    localparam int CH = 6;
    localparam int RS = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pan_wr;
    logic [2:0]  pan_ch;
    logic [6:0]  pan_val;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [15:0] in_sample;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic [CH-1:0] ramp_active;

    fm_pan_mixer #(.CHANNELS(CH), .SAMPLE_W(16), .PAN_W(7), .RAMP_STEP(RS)) dut (
        .clk(clk), .reset_n(reset_n), .pan_wr(pan_wr), .pan_ch(pan_ch),
        .pan_val(pan_val), .in_valid(in_valid), .in_ch(in_ch),
        .in_sample(in_sample), .out_valid(out_valid), .out_ch(out_ch),
        .out_l(out_l), .out_r(out_r), .ramp_active(ramp_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_tgt [CH];
    int m_cur [CH];
    bit pv [3];
    int pch [3];
    int pl [3];
    int pr [3];
    logic [15:0] last_l, last_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Equal-power law: 255*cos of a quarter turn spread over positions 1..126.
    function automatic int gain(input int p);
        int r;
        if (p <= 0 || p >= 128) return 0;
        r = $rtoi(255.0 * $cos(real'(p - 1) * 3.14159265358979 / 2.0 / 126.0) + 0.5);
        return (r < 0) ? 0 : (r > 255 ? 255 : r);
    endfunction

    function automatic int scale(input int s, input int g);
        int prod;
        prod = s * g;
        return (prod >>> 8) & 32'hFFFF;
    endfunction

    function automatic logic [31:0] model_ramp();
        logic [31:0] v = '0;
        for (int n = 0; n < CH; n++) v[n] = (m_cur[n] != m_tgt[n]);
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < CH; n++) begin
            m_tgt[n] = 64;
            m_cur[n] = 64;
        end
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then check outputs after the edge.
    task automatic step(input bit wr, input int wch, input int wv,
                        input bit v, input int ich, input int smp);
        bit ev;
        int el, er, s, c;
        pan_wr = wr; pan_ch = wch[2:0]; pan_val = wv[6:0];
        in_valid = v; in_ch = ich[2:0]; in_sample = smp[15:0];
        if (wr && wch < CH) begin
            m_tgt[wch] = wv;
            if (RS == 0 || wv == 0 || m_cur[wch] == 0) m_cur[wch] = wv;
        end
        ev = v && (ich < CH);
        el = 0; er = 0;
        if (ev) begin
            c = m_cur[ich];
            if (m_tgt[ich] > c)      c = (c + RS < m_tgt[ich]) ? c + RS : m_tgt[ich];
            else if (m_tgt[ich] < c) c = (c - RS > m_tgt[ich]) ? c - RS : m_tgt[ich];
            m_cur[ich] = c;
            s = int'($signed(in_sample));
            el = scale(s, gain(c));
            er = scale(s, (c == 0) ? 0 : gain(128 - c));
        end
        @(posedge clk);
        #1;
        pv[2] = pv[1]; pch[2] = pch[1]; pl[2] = pl[1]; pr[2] = pr[1];
        pv[1] = pv[0]; pch[1] = pch[0]; pl[1] = pl[0]; pr[1] = pr[0];
        pv[0] = ev;    pch[0] = ich;    pl[0] = el;    pr[0] = er;
        chk("out_valid", 32'(out_valid), 32'(pv[2]));
        if (pv[2]) begin
            chk("out_ch", 32'(out_ch), 32'(pch[2]));
            chk("out_l", 32'(out_l), 32'(pl[2]));
            chk("out_r", 32'(out_r), 32'(pr[2]));
            last_l = out_l;
            last_r = out_r;
        end
        chk("ramp_active", 32'(ramp_active), model_ramp());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pan_wr = 0; in_valid = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_l", 32'(out_l), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_ramp", 32'(ramp_active), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; pan_wr = 0; pan_ch = 0; pan_val = 0;
        in_valid = 0; in_ch = 0; in_sample = 0;
        last_l = '0; last_r = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Centre pan on channel 0.
        step(0, 0, 0, 1, 0, 'h4000);
        idle(3);
        chk("centre_l", 32'(last_l), 32'h2D00);
        chk("centre_r", 32'(last_r), 32'h2D00);

        // Hard left on ch 2 via mute then immediate load.
        step(1, 2, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0);
        step(0, 0, 0, 1, 2, 'h4000);
        idle(3);
        chk("left_pos_l", 32'(last_l), 32'h3FC0);
        chk("left_pos_r", 32'(last_r), 32'h0000);
        step(0, 0, 0, 1, 2, 'h8000);
        idle(3);
        chk("left_neg_l", 32'(last_l), 32'h8080);
        chk("left_neg_r", 32'(last_r), 32'h0000);

        // Ramp ch 1 from centre to hard right.
        step(1, 1, 'h7F, 0, 0, 0);
        chk("ramp_start", 32'(ramp_active[1]), 32'd1);
        for (int i = 0; i < 63; i++) step(0, 0, 0, 1, 1, 'h4000);
        chk("ramp_done", 32'(ramp_active[1]), 32'd0);
        idle(3);
        chk("right_l", 32'(last_l), 32'h0000);
        chk("right_r", 32'(last_r), 32'h3FC0);

        // Mute mid-ramp on ch 3, then unmute to centre.
        step(1, 3, 'h7F, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 3, 'h1234 + i);
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 'h4000);
        idle(3);
        chk("mute_l", 32'(last_l), 32'h0000);
        chk("mute_r", 32'(last_r), 32'h0000);
        step(1, 3, 'h40, 0, 0, 0);
        step(0, 0, 0, 1, 3, 'h4000);
        idle(3);
        chk("unmute_l", 32'(last_l), 32'h2D00);
        chk("unmute_r", 32'(last_r), 32'h2D00);

        // Same-cycle write/sample on ch 4, interleaved with ch 5 and invalid channels.
        step(1, 4, 'h10, 1, 4, 'h4000);
        for (int i = 0; i < 20; i++) begin
            step((i % 5) == 0, 4, 'h10 + 7 * i, 1, (i % 2) ? 5 : 4, 'h7FFF - 311 * i);
            if (i % 6 == 0) step(0, 0, 0, 1, 6 + (i % 2), 'h5555);
        end
        step(1, 7, 'h01, 1, 7, 'h4000);
        idle(3);

        // Reset with three samples in flight.
        step(1, 0, 'h20, 1, 0, 'h1111);
        step(0, 0, 0, 1, 0, 'h2222);
        step(0, 0, 0, 1, 1, 'h3333);
        do_reset();
        idle(3);
        step(0, 0, 0, 1, 0, 'h4000);
        idle(3);
        chk("post_rst_l", 32'(last_l), 32'h2D00);
        chk("post_rst_r", 32'(last_r), 32'h2D00);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int wv;
            wv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), wv,
                 $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 65535)));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fm_pan_mixer.md
# fm_pan_mixer

Time-multiplexed stereo panner for the FM audio path. It accepts one mono sample per cycle tagged with a channel number, applies that channel's equal-power pan law to produce left and right samples, and ramps each channel's pan position toward its written target to avoid zipper noise. It sits between the FM operator/channel accumulator and the stereo output mixer. It generalises the fixed 7-bit left pan ROM into a parametrised L/R law with per-channel state and smoothing.

## Interface
- CHANNELS, 8, number of independent pan channels (≥1)
- SAMPLE_W, 16, signed sample width in and out
- PAN_W, 7, pan position width; 2^PAN_W entries in the law table
- RAMP_STEP, 1, pan units moved per processed sample; 0 = targets apply immediately

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- pan_wr  in  1  write strobe for a pan target
- pan_ch  in  $clog2(CHANNELS)  channel addressed by pan_wr
- pan_val  in  PAN_W  new target; 0 = mute, 1 = hard left, 2^PAN_W−1 = hard right
- in_valid  in  1  sample present this cycle
- in_ch  in  $clog2(CHANNELS)  channel of in_sample
- in_sample  in  SAMPLE_W  signed mono sample
- out_valid  out  1  out_l/out_r/out_ch valid
- out_ch  out  $clog2(CHANNELS)  channel of output pair
- out_l  out  SAMPLE_W  signed left sample
- out_r  out  SAMPLE_W  signed right sample
- ramp_active  out  CHANNELS  bit n set while channel n current ≠ target

## Operation
- Per channel: target[n] and current[n], both PAN_W bits; reset value 2^(PAN_W−1) (centre).
- Gain law G(p), p in 1..2^PAN_W−1: 8-bit unsigned, G(p) = round(255·cos((p−1)·π/2/(2^PAN_W−2))) clamped to 0..255, G(1)=0xFF, G(2^PAN_W−1)=0x00; for PAN_W=7 it equals the existing left pan table (G(64)=0xB4). Table generated at elaboration, distributed ROM.
- gain_l = G(p); gain_r = G(2^PAN_W − p); p = 0 → both gains 0.
- pan_wr: target[pan_ch] ← pan_val. pan_ch ≥ CHANNELS ignored. If RAMP_STEP = 0, or pan_val = 0, or current = 0, current ← pan_val as well (mute entry/exit is immediate).
- Ramp: on each accepted sample of channel c (stage 0), current[c] moves toward target[c] by RAMP_STEP, clamped so it never overshoots; the sample uses the post-step value.
- Same-cycle pan_wr and in_valid on the same channel: the write is forwarded; the step is computed against the new target (immediate-load cases above included).
- in_ch ≥ CHANNELS: sample dropped, no out_valid.
- ramp_active[n] = (current[n] ≠ target[n]), registered from state.
- Output arithmetic: out = (in_sample · {0,gain}) >>> 8, full SAMPLE_W+9-bit signed product, arithmetic shift (round toward −∞), never overflows.

## Timing
- No backpressure; one sample accepted every cycle in_valid = 1.
- Pipeline: S0 state read/step/update, S1 table lookup, S2 multiply/shift into output registers. Latency 3 cycles: in_valid at edge k → out_valid at edge k+3.
- Back-to-back samples on the same channel see the previous sample's updated current (state written in S0).
- pan_wr effective for a sample accepted the same or any later cycle.
- Reset: out_valid, out_ch, out_l, out_r ← 0; all pipeline valids cleared; current/target ← centre; ramp_active ← 0. Reset mid-stream discards in-flight samples; out_valid low from the first edge with reset_n = 0.

## Test plan
- After reset, ch 0, in_sample 0x4000 → 3 cycles later out_valid, out_l = out_r = 0x2D00.
- pan_wr ch 2 = 1, then in_sample 0x4000 on ch 2 with RAMP_STEP=0 → out_l 0x3FC0, out_r 0x0000; in_sample 0x8000 → out_l 0x8080, out_r 0x0000.
- RAMP_STEP=1, pan_wr ch 1 = 0x7F from centre → ramp_active[1] high; 63 samples on ch 1 step current 0x41..0x7F; 63rd sample out_l 0, out_r = 0x3FC0 for input 0x4000; ramp_active[1] clears.
- pan_wr ch 3 = 0 mid-ramp → next ch 3 sample outputs 0/0 immediately; pan_wr = 0x40 → next sample 0x2D00/0x2D00.
- Same-cycle pan_wr and in_valid on ch 4, interleaved with ch 5 every cycle → ch 4 steps against the new target, ch 5 unaffected; in_ch ≥ CHANNELS produces no output.
- Assert reset_n low with 3 samples in flight → no out_valid, all outputs 0, state back to centre.
